// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states, opcodes,
// ALUOp/ALUControl codes and datapath mux selects.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    localparam logic [2:0] ALUC_ADD = 3'b000;
    localparam logic [2:0] ALUC_SUB = 3'b001;
    localparam logic [2:0] ALUC_AND = 3'b010;
    localparam logic [2:0] ALUC_OR  = 3'b011;
    localparam logic [2:0] ALUC_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BR:   return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// ALU-decode request/response bundle between the control FSM (master) and the
// combinational ALU decoder (slave).
interface multicycle_control_unit_if #(parameter int ALUCTRL_W = 3);
    import mc_ctrl_pkg::*;

    alu_op_t              alu_op;
    logic [2:0]           funct3;
    logic                 funct7b5;
    logic                 op5;
    logic [ALUCTRL_W-1:0] alu_control;
    logic                 illegal_funct;

    // Purely combinational: the response is valid in the same cycle as the request.
    modport master (
        output alu_op, funct3, funct7b5, op5,
        input  alu_control, illegal_funct
    );

    modport slave (
        input  alu_op, funct3, funct7b5, op5,
        output alu_control, illegal_funct
    );

endinterface

// File: rtl/mc_alu_decoder.sv
// Combinational ALUOp/funct3/funct7b5/op5 -> ALUControl decode, flagging
// funct3 values the ALU does not implement.
module mc_alu_decoder #(
    parameter int ALUCTRL_W = 3
) (
    multicycle_control_unit_if.slave dec
);
    import mc_ctrl_pkg::*;

    always_comb begin
        dec.alu_control   = ALUCTRL_W'(ALUC_ADD);
        dec.illegal_funct = 1'b0;
        case (dec.alu_op)
            ALUOP_ADD: dec.alu_control = ALUCTRL_W'(ALUC_ADD);
            ALUOP_SUB: dec.alu_control = ALUCTRL_W'(ALUC_SUB);
            ALUOP_FUNCT: begin
                case (dec.funct3)
                    // Only R-type (op[5]=1) can encode sub; addi with imm[10]=1 stays add.
                    3'b000:  dec.alu_control = (dec.op5 & dec.funct7b5) ? ALUCTRL_W'(ALUC_SUB)
                                                                        : ALUCTRL_W'(ALUC_ADD);
                    3'b010:  dec.alu_control = ALUCTRL_W'(ALUC_SLT);
                    3'b110:  dec.alu_control = ALUCTRL_W'(ALUC_OR);
                    3'b111:  dec.alu_control = ALUCTRL_W'(ALUC_AND);
                    default: dec.illegal_funct = 1'b1;
                endcase
            end
            default: dec.alu_control = ALUCTRL_W'(ALUC_ADD);
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: per-state enables/mux selects, memory-ready
// stalls, BEQ/BNE resolution, illegal-instruction pulse and retired count.
module multicycle_control_unit #(
    parameter bit USE_MEM_READY = 1'b1,
    parameter bit SUPPORT_BNE   = 1'b1,
    parameter int CNT_W         = 32,
    parameter int ALUCTRL_W     = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          Instr,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic                 RegWrite,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 illegal_instr,
    output logic [CNT_W-1:0]     instr_retired,
    output logic [3:0]           state
);
    import mc_ctrl_pkg::*;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [6:0] op;
    logic [2:0] funct3;
    logic       mem_ok;
    logic       pc_update;
    logic       branch;
    logic       taken;
    logic       br_illegal;
    logic       retire;
    alu_op_t    alu_op;

    logic unused_instr_bits;

    multicycle_control_unit_if #(.ALUCTRL_W(ALUCTRL_W)) alu_bus ();

    mc_alu_decoder #(.ALUCTRL_W(ALUCTRL_W)) u_alu_dec (.dec(alu_bus.slave));

    assign op                = Instr[6:0];
    assign funct3            = Instr[14:12];
    assign mem_ok            = USE_MEM_READY ? mem_ready : 1'b1;
    assign unused_instr_bits = ^{Instr[31], Instr[29:15], Instr[11:7]};

    always_comb begin
        alu_bus.alu_op   = alu_op;
        alu_bus.funct3   = funct3;
        alu_bus.funct7b5 = Instr[30];
        alu_bus.op5      = op[5];
    end

    always_comb begin
        taken      = 1'b0;
        br_illegal = 1'b0;
        case (funct3)
            3'b000:  taken = zero;
            3'b001: begin
                if (SUPPORT_BNE) taken      = ~zero;
                else             br_illegal = 1'b1;
            end
            default: br_illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        pc_update     = 1'b0;
        branch        = 1'b0;
        retire        = 1'b0;
        alu_op        = ALUOP_ADD;
        AdrSrc        = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        ResultSrc     = RES_ALUOUT;
        ALUSrcA       = SRCA_PC;
        ALUSrcB       = SRCB_RS2;
        RegWrite      = 1'b0;
        illegal_instr = 1'b0;

        case (state_q)
            S_FETCH: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                if (mem_ok) begin
                    IRWrite   = 1'b1;
                    pc_update = 1'b1;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BR:        state_d = S_BRANCH;
                    default: begin
                        illegal_instr = 1'b1;
                        state_d       = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ok) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (mem_ok) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXECUTER: begin
                ALUSrcA       = SRCA_RS1;
                ALUSrcB       = SRCB_RS2;
                alu_op        = ALUOP_FUNCT;
                illegal_instr = alu_bus.illegal_funct;
                state_d       = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_EXECUTEI: begin
                ALUSrcA       = SRCA_RS1;
                ALUSrcB       = SRCB_IMM;
                alu_op        = ALUOP_FUNCT;
                illegal_instr = alu_bus.illegal_funct;
                state_d       = S_ALUWB;
            end
            S_JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            S_BRANCH: begin
                ALUSrcA       = SRCA_RS1;
                ALUSrcB       = SRCB_RS2;
                alu_op        = ALUOP_SUB;
                branch        = 1'b1;
                illegal_instr = br_illegal;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;

        PCWrite       = pc_update | (branch & taken);
        ImmSrc        = imm_src_of(op);
        ALUControl    = alu_bus.alu_control;
        instr_retired = cnt_q;
        state         = state_q;

        // Reset dominates every output, including the debug state and count.
        if (reset) begin
            PCWrite       = 1'b0;
            AdrSrc        = 1'b0;
            MemWrite      = 1'b0;
            IRWrite       = 1'b0;
            ResultSrc     = 2'b00;
            ALUSrcA       = 2'b00;
            ALUSrcB       = 2'b00;
            ImmSrc        = 2'b00;
            RegWrite      = 1'b0;
            ALUControl    = '0;
            illegal_instr = 1'b0;
            instr_retired = '0;
            state         = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: scripted instruction sequences
// with hand-computed per-cycle control outputs.
module tb_multicycle_control_unit;

    logic        clk;
    logic        reset;
    logic [31:0] Instr;
    logic        zero;
    logic        mem_ready;

    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_instr;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0]  ALUControl;
    logic [31:0] instr_retired;
    logic [3:0]  state;

    logic        nb_PCWrite, nb_AdrSrc, nb_MemWrite, nb_IRWrite, nb_RegWrite, nb_illegal;
    logic [1:0]  nb_ResultSrc, nb_ALUSrcA, nb_ALUSrcB, nb_ImmSrc;
    logic [2:0]  nb_ALUControl;
    logic [31:0] nb_retired;
    logic [3:0]  nb_state;

    int n_checks;
    int n_pass;
    int cycle_cnt;
    int start_cyc;

    multicycle_control_unit dut (
        .clk(clk), .reset(reset), .Instr(Instr), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .RegWrite(RegWrite), .ALUControl(ALUControl), .illegal_instr(illegal_instr),
        .instr_retired(instr_retired), .state(state)
    );

    multicycle_control_unit #(.SUPPORT_BNE(1'b0)) dut_nb (
        .clk(clk), .reset(reset), .Instr(Instr), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(nb_PCWrite), .AdrSrc(nb_AdrSrc), .MemWrite(nb_MemWrite), .IRWrite(nb_IRWrite),
        .ResultSrc(nb_ResultSrc), .ALUSrcA(nb_ALUSrcA), .ALUSrcB(nb_ALUSrcB), .ImmSrc(nb_ImmSrc),
        .RegWrite(nb_RegWrite), .ALUControl(nb_ALUControl), .illegal_instr(nb_illegal),
        .instr_retired(nb_retired), .state(nb_state)
    );

    wire [52:0] all_outs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                            ImmSrc, RegWrite, ALUControl, illegal_instr, instr_retired, state};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cycle_cnt);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        cycle_cnt++;
    endtask

    task automatic at(input logic mr);
        mem_ready = mr;
        #1;
    endtask

    // Fetch then decode with mem_ready high, leaving the FSM in the execute state.
    task automatic fetch_decode(input logic [31:0] ins);
        Instr = ins;
        at(1'b1);
        check("fd_fetch_state", 64'(state), 64'd0);
        cyc();
        at(1'b1);
        check("fd_decode_state", 64'(state), 64'd1);
        cyc();
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        cycle_cnt = 0;
        reset     = 1'b1;
        Instr     = 32'h002081B3;
        zero      = 1'b0;
        mem_ready = 1'b1;

        for (int i = 0; i < 3; i++) begin
            cyc();
            check("reset_outs_zero", 64'(all_outs), 64'd0);
        end
        reset = 1'b0;

        // add x3,x1,x2
        at(1'b1);
        check("add_fetch_state", 64'(state), 64'd0);
        check("add_fetch_irwrite", 64'(IRWrite), 64'd1);
        check("add_fetch_pcwrite", 64'(PCWrite), 64'd1);
        check("add_fetch_srcb", 64'(ALUSrcB), 64'd2);
        check("add_fetch_result", 64'(ResultSrc), 64'd2);
        cyc(); at(1'b1);
        check("add_decode_state", 64'(state), 64'd1);
        check("add_decode_srca", 64'(ALUSrcA), 64'd1);
        check("add_decode_regwrite", 64'(RegWrite), 64'd0);
        cyc(); at(1'b1);
        check("add_execr_state", 64'(state), 64'd6);
        check("add_execr_aluctl", 64'(ALUControl), 64'd0);
        check("add_execr_srca", 64'(ALUSrcA), 64'd2);
        check("add_execr_regwrite", 64'(RegWrite), 64'd0);
        cyc(); at(1'b1);
        check("add_aluwb_state", 64'(state), 64'd7);
        check("add_aluwb_regwrite", 64'(RegWrite), 64'd1);
        cyc(); at(1'b1);
        check("add_back_fetch", 64'(state), 64'd0);
        check("add_retired", 64'(instr_retired), 64'd1);

        // lw x6,0(x5) with stalls in FETCH and MEMREAD
        Instr     = 32'h0002A303;
        start_cyc = cycle_cnt;
        for (int i = 0; i < 2; i++) begin
            at(1'b0);
            check("lw_stall_state", 64'(state), 64'd0);
            check("lw_stall_irwrite", 64'(IRWrite), 64'd0);
            check("lw_stall_pcwrite", 64'(PCWrite), 64'd0);
            cyc();
        end
        at(1'b1);
        check("lw_ready_irwrite", 64'(IRWrite), 64'd1);
        check("lw_ready_pcwrite", 64'(PCWrite), 64'd1);
        cyc(); at(1'b1);
        check("lw_decode_immsrc", 64'(ImmSrc), 64'd0);
        cyc(); at(1'b1);
        check("lw_memadr_state", 64'(state), 64'd2);
        cyc();
        for (int i = 0; i < 3; i++) begin
            at(1'b0);
            check("lw_memread_state", 64'(state), 64'd3);
            check("lw_memread_adrsrc", 64'(AdrSrc), 64'd1);
            check("lw_memread_regwrite", 64'(RegWrite), 64'd0);
            cyc();
        end
        at(1'b1);
        check("lw_memread_ready", 64'(state), 64'd3);
        cyc(); at(1'b1);
        check("lw_memwb_state", 64'(state), 64'd4);
        check("lw_memwb_regwrite", 64'(RegWrite), 64'd1);
        check("lw_memwb_result", 64'(ResultSrc), 64'd1);
        cyc(); at(1'b1);
        check("lw_total_cycles", 64'(cycle_cnt - start_cyc), 64'd10);
        check("lw_back_fetch", 64'(state), 64'd0);
        check("lw_retired", 64'(instr_retired), 64'd2);

        // sw x6,4(x5) with a 2-cycle memory delay
        Instr = 32'h0062A223;
        at(1'b1);
        cyc(); at(1'b1);
        check("sw_decode_immsrc", 64'(ImmSrc), 64'd1);
        cyc(); at(1'b1);
        check("sw_memadr_state", 64'(state), 64'd2);
        cyc();
        for (int i = 0; i < 3; i++) begin
            at(i == 2);
            check("sw_memwrite_state", 64'(state), 64'd5);
            check("sw_memwrite_strobe", 64'(MemWrite), 64'd1);
            check("sw_memwrite_adrsrc", 64'(AdrSrc), 64'd1);
            check("sw_memwrite_immsrc", 64'(ImmSrc), 64'd1);
            check("sw_hold_count", 64'(instr_retired), 64'd2);
            cyc();
        end
        at(1'b1);
        check("sw_back_fetch", 64'(state), 64'd0);
        check("sw_memwrite_off", 64'(MemWrite), 64'd0);
        check("sw_retired", 64'(instr_retired), 64'd3);

        // beq taken, beq not taken, bne taken (not taken without BNE support)
        zero = 1'b1;
        fetch_decode(32'h00208463);
        at(1'b1);
        check("beq1_state", 64'(state), 64'd10);
        check("beq1_pcwrite", 64'(PCWrite), 64'd1);
        check("beq1_aluctl", 64'(ALUControl), 64'd1);
        check("beq1_immsrc", 64'(ImmSrc), 64'd2);
        check("beq1_illegal", 64'(illegal_instr), 64'd0);
        cyc();
        zero = 1'b0;
        fetch_decode(32'h00208463);
        at(1'b1);
        check("beq0_pcwrite", 64'(PCWrite), 64'd0);
        check("beq0_aluctl", 64'(ALUControl), 64'd1);
        cyc();
        fetch_decode(32'h00209463);
        at(1'b1);
        check("bne_pcwrite", 64'(PCWrite), 64'd1);
        check("bne_nobne_pcwrite", 64'(nb_PCWrite), 64'd0);
        check("bne_nobne_state", 64'(nb_state), 64'd10);
        check("bne_illegal", 64'(illegal_instr), 64'd0);
        cyc(); at(1'b1);
        check("branch_retired", 64'(instr_retired), 64'd6);
        check("nobne_retired", 64'(nb_retired), 64'd6);

        // illegal opcode 0x7F
        Instr = 32'h0000007F;
        at(1'b1);
        check("ill_fetch_flag", 64'(illegal_instr), 64'd0);
        cyc(); at(1'b1);
        check("ill_decode_state", 64'(state), 64'd1);
        check("ill_decode_flag", 64'(illegal_instr), 64'd1);
        check("ill_decode_regwrite", 64'(RegWrite), 64'd0);
        check("ill_decode_memwrite", 64'(MemWrite), 64'd0);
        cyc(); at(1'b1);
        check("ill_back_fetch", 64'(state), 64'd0);
        check("ill_flag_cleared", 64'(illegal_instr), 64'd0);
        check("ill_retired", 64'(instr_retired), 64'd6);

        // jal x1,8 with reset landing in ALUWB
        Instr = 32'h008000EF;
        at(1'b1);
        cyc(); at(1'b1);
        check("jal_decode_immsrc", 64'(ImmSrc), 64'd3);
        cyc(); at(1'b1);
        check("jal_state", 64'(state), 64'd9);
        check("jal_pcwrite", 64'(PCWrite), 64'd1);
        check("jal_srca", 64'(ALUSrcA), 64'd1);
        check("jal_srcb", 64'(ALUSrcB), 64'd2);
        check("jal_immsrc", 64'(ImmSrc), 64'd3);
        check("jal_regwrite", 64'(RegWrite), 64'd0);
        cyc(); at(1'b1);
        check("jal_aluwb_state", 64'(state), 64'd7);
        check("jal_aluwb_regwrite", 64'(RegWrite), 64'd1);
        reset = 1'b1;
        #1;
        check("jal_reset_outs_zero", 64'(all_outs), 64'd0);
        cyc();
        reset = 1'b0;
        at(1'b1);
        check("jal_reset_fetch", 64'(state), 64'd0);
        check("jal_reset_count", 64'(instr_retired), 64'd0);
        check("jal_reset_irwrite", 64'(IRWrite), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
